cpu_run_monitor: RTL

Synthesizable run-control and result monitor for the RV32I core. It sits beside `cpu` and observes the retire PC and the register-file write port. It detects program completion, either at a halt address or on a self-loop, and enforces a cycle timeout. It also counts cycles and retired instructions, shadows a parametrised set of architectural registers, and flags pass/fail against an expected result. Self-checking regressions and on-board runs use it in place of bench-side register peeking and fixed `$finish` delays.

---
 rtl/rv32_dbg_pkg.sv | 19 +
 rtl/pc_loop_detector.sv | 49 ++++
 rtl/cpu_run_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32_dbg_pkg.sv
// Shared debug/run-control definitions for the RV32I core monitors.
package rv32_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

    localparam logic [4:0] REG_SP = 5'd2;
    localparam logic [4:0] REG_S0 = 5'd8;
    localparam logic [4:0] REG_S1 = 5'd9;
    localparam logic [4:0] REG_A5 = 5'd15;
    localparam logic [4:0] REG_A4 = 5'd14;
    localparam logic [4:0] REG_A0 = 5'd10;
    localparam logic [4:0] REG_S2 = 5'd18;

endpackage

// File: rtl/pc_loop_detector.sv
// Detects LOOP_LIMIT consecutive retires of one PC (a self-loop halt idiom).
module pc_loop_detector #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LOOP_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            retire,
    input  logic [XLEN-1:0] pc,
    output logic            loop_hit
);

    localparam int unsigned SC_W = $clog2(LOOP_LIMIT + 2);

    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [SC_W-1:0] same_q, same_d, same_inc;

    always_comb begin
        // Saturating so a long self-loop never wraps back through the limit.
        if (pc == last_pc_q)
            same_inc = (same_q == '1) ? same_q : same_q + 1'b1;
        else
            same_inc = SC_W'(1);

        same_d    = same_q;
        last_pc_d = last_pc_q;
        if (clear) begin
            same_d    = '0;
            last_pc_d = '0;
        end else if (retire) begin
            same_d    = same_inc;
            last_pc_d = pc;
        end

        loop_hit = (LOOP_LIMIT != 0) && retire && (same_inc == SC_W'(LOOP_LIMIT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            same_q    <= '0;
            last_pc_q <= '0;
        end else begin
            same_q    <= same_d;
            last_pc_q <= last_pc_d;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and result monitor: halt/timeout detection, counters and
// architectural register shadows observed from the retire and RF write ports.
module cpu_run_monitor
    import rv32_dbg_pkg::*;
#(
    parameter int unsigned           XLEN       = 32,
    parameter int unsigned           N_WATCH    = 8,
    parameter logic [5*N_WATCH-1:0]  WATCH_IDX  = {REG_SP, REG_S0, REG_S1, REG_S2,
                                                   REG_A5, REG_A4, REG_A0, 5'd1},
    parameter logic [4:0]            CHECK_REG  = REG_A0,
    parameter logic [XLEN-1:0]       HALT_PC    = 32'hFFFF_FFFC,
    parameter int unsigned           LOOP_LIMIT = 4,
    parameter int unsigned           MAX_CYCLES = 1000,
    parameter int unsigned           CNT_W      = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [XLEN-1:0]                               expected,
    input  logic                                          retire,
    input  logic [XLEN-1:0]                               pc,
    input  logic                                          rf_we,
    input  logic [4:0]                                    rf_waddr,
    input  logic [XLEN-1:0]                               rf_wdata,
    input  logic [((N_WATCH > 1) ? $clog2(N_WATCH) : 1)-1:0] rd_sel,
    output logic [XLEN-1:0]                               rd_data,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          pass,
    output logic                                          timeout,
    output logic [CNT_W-1:0]                              cycle_cnt,
    output logic [CNT_W-1:0]                              instr_cnt,
    output logic [XLEN-1:0]                               result
);

    localparam int unsigned SEL_W = (N_WATCH > 1) ? $clog2(N_WATCH) : 1;

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
    logic [XLEN-1:0]  result_q, result_d, result_new;
    logic             pass_q, pass_d;
    logic [XLEN-1:0]  shadow_q [N_WATCH];
    logic [XLEN-1:0]  shadow_d [N_WATCH];
    logic             wr_ok, halt, loop_hit, loop_clear, run_retire;

    assign run_retire = retire && (state_q == ST_RUN);

    pc_loop_detector #(
        .XLEN      (XLEN),
        .LOOP_LIMIT(LOOP_LIMIT)
    ) u_loop (
        .clk     (clk),
        .rst     (rst),
        .clear   (loop_clear),
        .retire  (run_retire),
        .pc      (pc),
        .loop_hit(loop_hit)
    );

    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        instr_d    = instr_q;
        result_d   = result_q;
        pass_d     = pass_q;
        shadow_d   = shadow_q;
        loop_clear = 1'b0;

        wr_ok      = rf_we && (rf_waddr != '0);
        // pass must see a CHECK_REG write landing in the halting cycle itself.
        result_new = (wr_ok && rf_waddr == CHECK_REG) ? rf_wdata : result_q;
        halt       = run_retire && ((pc == HALT_PC) || loop_hit);

        case (state_q)
            ST_RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
                if (retire && instr_q != '1) instr_d = instr_q + 1'b1;
                for (int unsigned i = 0; i < N_WATCH; i++)
                    if (wr_ok && rf_waddr == WATCH_IDX[5*i +: 5]) shadow_d[i] = rf_wdata;
                result_d = result_new;
                if (halt) begin
                    state_d = ST_HALTED;
                    pass_d  = (result_new == expected);
                end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cycle_d    = '0;
                    instr_d    = '0;
                    result_d   = '0;
                    pass_d     = 1'b0;
                    shadow_d   = '{default: '0};
                    loop_clear = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cycle_q  <= '0;
            instr_q  <= '0;
            result_q <= '0;
            pass_q   <= 1'b0;
            for (int unsigned i = 0; i < N_WATCH; i++) shadow_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N_WATCH; i++)
            if (rd_sel == SEL_W'(i)) rd_data = shadow_q[i];
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    assign timeout   = (state_q == ST_TIMEOUT);
    assign pass      = pass_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign result    = result_q;

endmodule
